// File: rtl/syn_gpu_pkg.sv
// Shared canvas geometry, pixel pointer and FIFO status types for the GPU memory-FIFO blocks.
package syn_gpu_pkg;

    localparam int unsigned P_CANVAS_W = 32;
    localparam int unsigned P_CANVAS_H = 32;
    localparam int unsigned P_X_W      = $clog2(P_CANVAS_W);
    localparam int unsigned P_Y_W      = 8;

    typedef struct packed {
        logic [P_Y_W-1:0] y;
        logic [P_X_W-1:0] x;
    } point_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
    } mff_status_t;

    // First pixel of a canvas row.
    function automatic point_t start_point(input int unsigned row);
        point_t p;
        p.y = P_Y_W'(row);
        p.x = '0;
        return p;
    endfunction

endpackage

// File: rtl/syn_gpu_mff_ch_ptr.sv
// One SRAM FIFO channel: write/read canvas pointers, occupancy count, status and sticky errors.
module syn_gpu_mff_ch_ptr
    import syn_gpu_pkg::*;
#(
    parameter int unsigned P_START_Y  = 32,
    parameter int unsigned P_CH_ROWS  = 16,
    parameter int unsigned P_X_STEP   = 4,
    parameter int unsigned P_CH_DEPTH = 128,
    parameter int unsigned P_AFULL_TH = 120
)(
    input  logic        clk_ir,
    input  logic        rst_sync,
    input  logic        wr,
    input  logic        rd,
    input  logic        flush,
    input  logic        err_clr,
    output point_t      wptr,
    output point_t      rptr,
    output mff_status_t status,
    output logic        ovf,
    output logic        udf
);

    localparam int unsigned CNT_W   = $clog2(P_CH_DEPTH + 1);
    localparam point_t      START_P = start_point(P_START_Y);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_nxt;
    logic             wr_ok;
    logic             rd_ok;
    logic             ovf_set;
    logic             udf_set;

    // Raster step inside the channel's row band, wrapping back to its first row.
    function automatic point_t advance(input point_t p);
        point_t n;
        n = p;
        if (p.x == P_X_W'(P_CANVAS_W - P_X_STEP)) begin
            n.x = '0;
            if (p.y == P_Y_W'(P_START_Y + P_CH_ROWS - 1)) n.y = P_Y_W'(P_START_Y);
            else                                          n.y = p.y + P_Y_W'(1);
        end else begin
            n.x = p.x + P_X_W'(P_X_STEP);
        end
        return n;
    endfunction

    // Flush masks both accesses and any error they would otherwise raise.
    always_comb begin
        wr_ok   = wr && !status.full  && !flush;
        rd_ok   = rd && !status.empty && !flush;
        ovf_set = wr &&  status.full  && !flush;
        udf_set = rd &&  status.empty && !flush;
        cnt_nxt = count;
        if (flush)               cnt_nxt = '0;
        else if (wr_ok && !rd_ok) cnt_nxt = count + CNT_W'(1);
        else if (rd_ok && !wr_ok) cnt_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clk_ir or posedge rst_sync) begin
        if (rst_sync) begin
            wptr         <= START_P;
            rptr         <= START_P;
            count        <= '0;
            status.full  <= 1'b0;
            status.empty <= 1'b1;
            status.afull <= 1'b0;
            ovf          <= 1'b0;
            udf          <= 1'b0;
        end else begin
            if (flush) begin
                wptr <= START_P;
                rptr <= START_P;
            end else begin
                if (wr_ok) wptr <= advance(wptr);
                if (rd_ok) rptr <= advance(rptr);
            end
            count        <= cnt_nxt;
            status.full  <= (cnt_nxt == CNT_W'(P_CH_DEPTH));
            status.empty <= (cnt_nxt == '0);
            status.afull <= (cnt_nxt >= CNT_W'(P_AFULL_TH));
            ovf          <= ovf_set || (ovf && !err_clr);
            udf          <= udf_set || (udf && !err_clr);
        end
    end

endmodule

// File: rtl/syn_gpu_mff_cntrlr.sv
// Multi-channel SRAM FIFO controller: per-channel canvas pointers with muxed address outputs.
module syn_gpu_mff_cntrlr
    import syn_gpu_pkg::*;
#(
    parameter  int unsigned P_NUM_CH    = 4,
    parameter  int unsigned P_CH_ROWS   = 16,
    parameter  int unsigned P_X_STEP    = 4,
    parameter  int unsigned P_FF_BASE_Y = P_CANVAS_H,
    parameter  int unsigned P_AFULL_TH  = P_CH_ROWS * P_CANVAS_W / P_X_STEP - 8,
    localparam int unsigned P_CH_DEPTH  = P_CH_ROWS * P_CANVAS_W / P_X_STEP,
    localparam int unsigned CH_W        = (P_NUM_CH > 1) ? $clog2(P_NUM_CH) : 1
)(
    input  logic                clk_ir,
    input  logic                rst_sync,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic                rd_en,
    input  logic [CH_W-1:0]     rd_ch,
    input  logic [P_NUM_CH-1:0] flush,
    input  logic                err_clr,
    output point_t              waddr,
    output point_t              raddr,
    output logic [P_NUM_CH-1:0] full,
    output logic [P_NUM_CH-1:0] empty,
    output logic [P_NUM_CH-1:0] afull,
    output logic [P_NUM_CH-1:0] ovf,
    output logic [P_NUM_CH-1:0] udf
);

    point_t      wptr [P_NUM_CH];
    point_t      rptr [P_NUM_CH];
    mff_status_t st   [P_NUM_CH];

    logic            wr_in_rng;
    logic            rd_in_rng;
    logic [CH_W-1:0] wsel;
    logic [CH_W-1:0] rsel;

    assign wr_in_rng = 32'(wr_ch) < P_NUM_CH;
    assign rd_in_rng = 32'(rd_ch) < P_NUM_CH;

    for (genvar c = 0; c < P_NUM_CH; c++) begin : g_ch
        syn_gpu_mff_ch_ptr #(
            .P_START_Y  (P_FF_BASE_Y + c * P_CH_ROWS),
            .P_CH_ROWS  (P_CH_ROWS),
            .P_X_STEP   (P_X_STEP),
            .P_CH_DEPTH (P_CH_DEPTH),
            .P_AFULL_TH (P_AFULL_TH)
        ) u_ch (
            .clk_ir   (clk_ir),
            .rst_sync (rst_sync),
            .wr       (wr_en && wr_in_rng && (wr_ch == CH_W'(c))),
            .rd       (rd_en && rd_in_rng && (rd_ch == CH_W'(c))),
            .flush    (flush[c]),
            .err_clr  (err_clr),
            .wptr     (wptr[c]),
            .rptr     (rptr[c]),
            .status   (st[c]),
            .ovf      (ovf[c]),
            .udf      (udf[c])
        );

        assign full[c]  = st[c].full;
        assign empty[c] = st[c].empty;
        assign afull[c] = st[c].afull;
    end

    // Out-of-range selects and reset both fall back to channel 0.
    assign wsel  = (rst_sync || !wr_in_rng) ? '0 : wr_ch;
    assign rsel  = (rst_sync || !rd_in_rng) ? '0 : rd_ch;
    assign waddr = wptr[wsel];
    assign raddr = rptr[rsel];

endmodule

// File: doc/syn_gpu_mff_cntrlr.md
SYN_GPU_MFF_CNTRLR -- requirements
Module: syn_gpu_mff_cntrlr

Interface
REQ-001 The module SHALL use parameter P_NUM_CH, default 4, meaning the number of independent FIFO channels in SRAM; legal range 1..8.
REQ-002 The module SHALL use parameter P_CH_ROWS, default 16, meaning the canvas rows given to each channel.
REQ-003 The module SHALL use parameter P_X_STEP, default 4, meaning the pixels per SRAM word, which is the x increment per access.
REQ-004 The module SHALL use parameter P_FF_BASE_Y, default P_CANVAS_H, meaning the first row of channel 0; channel c SHALL start at row P_FF_BASE_Y + c*P_CH_ROWS.
REQ-005 The module SHALL use parameter P_AFULL_TH, default P_CH_DEPTH-8, meaning the almost-full threshold in words.
REQ-006 Port clk_ir, input, 1 bit, SHALL be the single clock.
REQ-007 Port rst_sync, input, 1 bit, SHALL be the reset: asynchronous and active-high.
REQ-008 Ports wr_en (1) and wr_ch (CH_W), both inputs, SHALL carry the write request and its target channel.
REQ-009 Ports rd_en (1) and rd_ch (CH_W), both inputs, SHALL carry the read request and its source channel.
REQ-010 Port flush, input, P_NUM_CH bits, SHALL carry per-channel synchronous flush requests.
REQ-011 Port err_clr, input, 1 bit, SHALL clear all sticky error flags.
REQ-012 Ports waddr and raddr, outputs, point_t, SHALL carry the current pointers of wr_ch and rd_ch.
REQ-013 Ports full, empty and afull, outputs, P_NUM_CH bits each, SHALL carry per-channel status.
REQ-014 Ports ovf and udf, outputs, P_NUM_CH bits each, SHALL carry sticky overflow and underflow flags.

Function
REQ-015 P_CH_DEPTH SHALL equal P_CH_ROWS*P_CANVAS_W/P_X_STEP words; CH_W SHALL equal max(1,clog2(P_NUM_CH)); each per-channel count SHALL be clog2(P_CH_DEPTH+1) bits.
REQ-016 A valid write SHALL be wr_en & wr_ch<P_NUM_CH & ~full[wr_ch] & ~flush[wr_ch]; a valid read SHALL be defined the same way with rd_en, rd_ch and empty.
REQ-017 On each valid access, the pointer SHALL advance: x += P_X_STEP; at x==P_CANVAS_W-P_X_STEP, x SHALL go to 0 and y SHALL increment; at the last row of the channel, y SHALL return to the channel start row.
REQ-018 waddr and raddr SHALL be a combinational mux of the registered pointers, so an access uses the current pointer and the advanced pointer is visible next cycle.
REQ-019 The count SHALL rise by 1 on a valid write, fall by 1 on a valid read, and stay unchanged on a valid read and write to the same channel in the same cycle.
REQ-020 full, empty and afull SHALL be registered from the next count (full: ==P_CH_DEPTH; empty: ==0; afull: >=P_AFULL_TH), so status is correct the cycle after the access.
REQ-021 A write to a full channel SHALL be dropped and SHALL set ovf[ch]; a read from an empty channel SHALL be dropped and SHALL set udf[ch].
REQ-022 On an empty channel, a simultaneous read and write SHALL accept the write only and SHALL set udf; on a full channel, it SHALL accept the read only and SHALL set ovf.
REQ-023 flush[c] SHALL return both pointers of channel c to its start point and SHALL zero its count in the next cycle; it SHALL override same-cycle accesses to c, without setting any error flag.
REQ-024 Out-of-range wr_ch or rd_ch SHALL cause no state change; the address outputs SHALL then show channel 0 pointers.
REQ-025 When err_clr and a new error occur in the same cycle, setting the flag SHALL win.

Reset
REQ-026 While rst_sync is high: all pointers SHALL be at their channel start points, counts 0, empty all ones, full/afull/ovf/udf all zeros; waddr/raddr SHALL show channel 0 start.
REQ-027 Reset asserted mid-operation SHALL discard all channel contents immediately, without waiting for a clock edge.

Structure
REQ-028 point_t, P_CANVAS_W/H, P_X_W/P_Y_W and a new mff_status_t (full, empty, afull) SHALL live in syn_gpu_pkg.
REQ-029 One sub-module, syn_gpu_mff_ch_ptr, SHALL hold a single channel's pointer pair, count and flags; the top SHALL instantiate it P_NUM_CH times and mux the outputs.

Verification
REQ-030 Reset, then 3 writes to channel 1 -> waddr x 0,4,8 on row P_CANVAS_H+16; empty[1]=0 next cycle; other channels untouched.
REQ-031 Fill channel 0 with P_CH_DEPTH writes -> full[0]=1; one extra write -> ovf[0]=1, pointer unchanged; waddr wraps to (0,P_CANVAS_H) after the last row.
REQ-032 Read and write to half-full channel 2 in the same cycle -> count constant, both pointers advance by 4.
REQ-033 Read on empty channel 3 with a simultaneous write -> write accepted, udf[3]=1; err_clr alone clears it; err_clr plus a new underflow keeps it at 1.
REQ-034 flush[1] with a same-cycle write to channel 1 -> no write, count 0, empty[1]=1, pointers at start, no ovf.
REQ-035 rst_sync pulsed between clock edges mid-burst -> all outputs at reset values immediately.
